// File: rtl/ts_id_arbiter.sv
// ts_id_arbiter: shares one event timestamper between N_REQ requesters and owns its event-ID pool.
// Optional define TS_ID_OWNER_CHECK_EN rejects end requests for free IDs or IDs owned by another requester.
module ts_id_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_start_valid,
    output logic [N_REQ-1:0]      req_start_ready,
    output logic [ID_W-1:0]       req_start_id,
    input  logic [N_REQ-1:0]      req_end_valid,
    output logic [N_REQ-1:0]      req_end_ready,
    input  logic [N_REQ*ID_W-1:0] req_end_id,
    output logic                  ts_start_valid,
    input  logic                  ts_start_ready,
    output logic [ID_W-1:0]       ts_start_id,
    output logic                  ts_end_valid,
    input  logic                  ts_end_ready,
    output logic [ID_W-1:0]       ts_end_id,
    input  logic                  ts_out_valid,
    input  logic                  ts_out_ready,
    input  logic [ID_W-1:0]       ts_out_id,
    output logic [ID_W:0]         free_cnt,
    output logic                  owner_err
);
    localparam int NID = 1 << ID_W;
    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [0:0] S_IDLE = 1'b0, S_ISSUE = 1'b1;
    localparam logic [0:0] E_IDLE = 1'b0, E_ISSUE = 1'b1;

    logic [NID-1:0]  r_pool;
    logic [ID_W:0]   r_free_cnt;
    logic [0:0]      r_s_state, r_e_state;
    logic [PW-1:0]   r_s_ptr, r_e_ptr;
    logic [ID_W-1:0] r_s_id, r_e_id;
    logic [PW-1:0]   w_s_win, w_e_win;
    logic [ID_W-1:0] w_alloc_id, w_e_id;
    logic            w_s_go, w_e_grant, w_e_fwd, w_free;

    // Scan in reverse search order so the last hit is the first requester at or after the pointer.
    always_comb begin
        w_s_win    = '0;
        w_e_win    = '0;
        w_alloc_id = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_start_valid[(int'(r_s_ptr) + k) % N_REQ]) w_s_win = PW'((int'(r_s_ptr) + k) % N_REQ);
            if (req_end_valid[(int'(r_e_ptr) + k) % N_REQ])   w_e_win = PW'((int'(r_e_ptr) + k) % N_REQ);
        end
        for (int k = NID - 1; k >= 0; k--)
            if (r_pool[k]) w_alloc_id = ID_W'(k);
    end

    assign w_s_go          = !rst && r_s_state == S_IDLE && |req_start_valid && r_free_cnt != '0;
    assign w_e_grant       = !rst && r_e_state == E_IDLE && |req_end_valid;
    assign w_e_id          = req_end_id[int'(w_e_win)*ID_W +: ID_W];
    assign w_free          = ts_out_valid && ts_out_ready && !r_pool[ts_out_id];
    assign req_start_ready = w_s_go ? N_REQ'(1) << w_s_win : '0;
    assign req_start_id    = w_s_go ? w_alloc_id : '0;
    assign req_end_ready   = w_e_grant ? N_REQ'(1) << w_e_win : '0;
    assign ts_start_valid  = r_s_state == S_ISSUE;
    assign ts_start_id     = r_s_id;
    assign ts_end_valid    = r_e_state == E_ISSUE;
    assign ts_end_id       = r_e_id;
    assign free_cnt        = r_free_cnt;

`ifdef TS_ID_OWNER_CHECK_EN
    logic [PW-1:0] r_owner [NID];
    logic          w_reject;

    always_ff @(posedge clk)
        if (w_s_go) r_owner[w_alloc_id] <= w_s_win;

    assign w_reject  = r_pool[w_e_id] || r_owner[w_e_id] != w_e_win;
    assign w_e_fwd   = w_e_grant && !w_reject;
    assign owner_err = w_e_grant && w_reject;
`else
    assign w_e_fwd   = w_e_grant;
    assign owner_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pool     <= '1;
            r_free_cnt <= (ID_W+1)'(NID);
        end else begin
            if (w_free) r_pool[ts_out_id] <= 1'b1;
            if (w_s_go) r_pool[w_alloc_id] <= 1'b0;
            r_free_cnt <= r_free_cnt + (ID_W+1)'(w_free) - (ID_W+1)'(w_s_go);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_state <= S_IDLE;
            r_s_ptr   <= '0;
            r_s_id    <= '0;
        end else if (w_s_go) begin
            r_s_state <= S_ISSUE;
            r_s_id    <= w_alloc_id;
            r_s_ptr   <= w_s_win == PW'(N_REQ - 1) ? '0 : w_s_win + 1'b1;
        end else if (ts_start_valid && ts_start_ready) begin
            r_s_state <= S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_state <= E_IDLE;
            r_e_ptr   <= '0;
            r_e_id    <= '0;
        end else if (w_e_grant) begin
            r_e_ptr <= w_e_win == PW'(N_REQ - 1) ? '0 : w_e_win + 1'b1;
            if (w_e_fwd) begin
                r_e_state <= E_ISSUE;
                r_e_id    <= w_e_id;
            end
        end else if (ts_end_valid && ts_end_ready) begin
            r_e_state <= E_IDLE;
        end
    end
endmodule

// File: tb/tb_ts_id_arbiter.sv
// tb_ts_id_arbiter: vector table, directed corner sequences and a randomized run against a pool model.
module tb_ts_id_arbiter;
    localparam int N = 4, W = 4, NID = 16;

    logic           clk = 1'b0, rst;
    logic [N-1:0]   req_start_valid, req_start_ready, req_end_valid, req_end_ready;
    logic [W-1:0]   req_start_id, ts_start_id, ts_end_id, ts_out_id;
    logic [N*W-1:0] req_end_id;
    logic           ts_start_valid, ts_start_ready, ts_end_valid, ts_end_ready;
    logic           ts_out_valid, ts_out_ready, owner_err;
    logic [W:0]     free_cnt;
    int             checks = 0, failures = 0;

    ts_id_arbiter #(.N_REQ(N), .ID_W(W)) dut (
        .clk(clk), .rst(rst),
        .req_start_valid(req_start_valid), .req_start_ready(req_start_ready), .req_start_id(req_start_id),
        .req_end_valid(req_end_valid), .req_end_ready(req_end_ready), .req_end_id(req_end_id),
        .ts_start_valid(ts_start_valid), .ts_start_ready(ts_start_ready), .ts_start_id(ts_start_id),
        .ts_end_valid(ts_end_valid), .ts_end_ready(ts_end_ready), .ts_end_id(ts_end_id),
        .ts_out_valid(ts_out_valid), .ts_out_ready(ts_out_ready), .ts_out_id(ts_out_id),
        .free_cnt(free_cnt), .owner_err(owner_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] exp_rdy;
        int           exp_id;
        logic         exp_tsv;
        int           exp_tsid;
        int           exp_cnt;
    } vec_t;
    vec_t tv[10];

    bit m_free[NID];
    int m_own[NID];
    int m_sptr, m_eptr, m_sid, m_eid;
    bit m_sb, m_eb;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_start_valid = '0; req_end_valid = '0; req_end_id = '0;
        ts_start_ready = 1'b1; ts_end_ready = 1'b1;
        ts_out_valid = 1'b0; ts_out_ready = 1'b0; ts_out_id = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    function automatic int first_from(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic model_cycle;
        int cnt, lid, sw, ew, eid;
        bit s_go, e_go, rej, fr;
        cnt = 0; lid = -1;
        for (int i = 0; i < NID; i++) if (m_free[i]) begin cnt++; if (lid < 0) lid = i; end
        sw   = first_from(req_start_valid, m_sptr);
        ew   = first_from(req_end_valid, m_eptr);
        s_go = !m_sb && sw >= 0 && cnt > 0;
        e_go = !m_eb && ew >= 0;
        eid  = (ew >= 0) ? int'(req_end_id[ew*W +: W]) : 0;
`ifdef TS_ID_OWNER_CHECK_EN
        rej = e_go && (m_free[eid] || m_own[eid] != ew);
`else
        rej = 1'b0;
`endif
        chk("rnd_start_ready", req_start_ready, s_go ? (1 << sw) : 0);
        if (s_go) chk("rnd_start_id", req_start_id, lid);
        chk("rnd_end_ready", req_end_ready, e_go ? (1 << ew) : 0);
        chk("rnd_ts_start_valid", ts_start_valid, m_sb);
        if (m_sb) chk("rnd_ts_start_id", ts_start_id, m_sid);
        chk("rnd_ts_end_valid", ts_end_valid, m_eb);
        if (m_eb) chk("rnd_ts_end_id", ts_end_id, m_eid);
        chk("rnd_free_cnt", free_cnt, cnt);
        chk("rnd_owner_err", owner_err, rej);
        fr = ts_out_valid && ts_out_ready && !m_free[ts_out_id];
        if (m_sb && ts_start_ready) m_sb = 1'b0;
        if (m_eb && ts_end_ready) m_eb = 1'b0;
        if (s_go) begin
            m_sb = 1'b1; m_sid = lid; m_free[lid] = 1'b0; m_own[lid] = sw; m_sptr = (sw + 1) % N;
        end
        if (e_go) begin
            m_eptr = (ew + 1) % N;
            if (!rej) begin m_eb = 1'b1; m_eid = eid; end
        end
        if (fr) m_free[ts_out_id] = 1'b1;
    endtask

    initial begin
        tv[0] = '{4'b0001, 0, 1'b0, -1, 16};
        tv[1] = '{4'b0000, -1, 1'b1, 0, 15};
        tv[2] = '{4'b0010, 1, 1'b0, -1, 15};
        tv[3] = '{4'b0000, -1, 1'b1, 1, 14};
        tv[4] = '{4'b0100, 2, 1'b0, -1, 14};
        tv[5] = '{4'b0000, -1, 1'b1, 2, 13};
        tv[6] = '{4'b1000, 3, 1'b0, -1, 13};
        tv[7] = '{4'b0000, -1, 1'b1, 3, 12};
        tv[8] = '{4'b0001, 4, 1'b0, -1, 12};
        tv[9] = '{4'b0000, -1, 1'b1, 4, 11};

        // reset state
        idle_inputs();
        rst = 1'b1;
        #3;
        chk("reset_free_cnt", free_cnt, 16);
        chk("reset_start_ready", req_start_ready, 0);
        chk("reset_ts_start_valid", ts_start_valid, 0);
        chk("reset_ts_end_valid", ts_end_valid, 0);
        chk("reset_owner_err", owner_err, 0);

        // single start then round-robin fairness
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req_start_valid = 4'hf;
            #1;
            chk($sformatf("vec%0d_start_ready", i), req_start_ready, tv[i].exp_rdy);
            if (tv[i].exp_id >= 0) chk($sformatf("vec%0d_start_id", i), req_start_id, tv[i].exp_id);
            chk($sformatf("vec%0d_ts_start_valid", i), ts_start_valid, tv[i].exp_tsv);
            if (tv[i].exp_tsid >= 0) chk($sformatf("vec%0d_ts_start_id", i), ts_start_id, tv[i].exp_tsid);
            chk($sformatf("vec%0d_free_cnt", i), free_cnt, tv[i].exp_cnt);
            step();
        end

        // exhaustion, held request, then reuse of a freed ID
        do_reset();
        req_start_valid = 4'b0001;
        repeat (32) step();
        #1;
        chk("exh_free_cnt", free_cnt, 0);
        chk("exh_ready_held", req_start_ready, 0);
        step();
        ts_out_valid = 1'b1; ts_out_ready = 1'b1; ts_out_id = 4'd5;
        #1;
        chk("exh_ready_same_cycle_free", req_start_ready, 0);
        step();
        ts_out_valid = 1'b0;
        #1;
        chk("exh_free_cnt_after_free", free_cnt, 1);
        chk("exh_regrant_ready", req_start_ready, 4'b0001);
        chk("exh_regrant_id", req_start_id, 5);
        step();
        req_start_valid = '0;
        #1;
        chk("exh_ts_start_id", ts_start_id, 5);

        // concurrent start and end, end held by backpressure
        do_reset();
        req_start_valid = 4'b0010;
        #1;
        chk("cc_alloc_id", req_start_id, 0);
        step();
        req_start_valid = '0;
        step();
        req_start_valid = 4'b0100; req_end_valid = 4'b0010; ts_end_ready = 1'b0;
        #1;
        chk("cc_start_ready", req_start_ready, 4'b0100);
        chk("cc_end_ready", req_end_ready, 4'b0010);
        step();
        req_start_valid = '0; req_end_valid = '0;
        #1;
        chk("cc_ts_start_valid", ts_start_valid, 1);
        chk("cc_ts_start_id", ts_start_id, 1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cc_hold%0d_valid", i), ts_end_valid, 1);
            chk($sformatf("cc_hold%0d_id", i), ts_end_id, 0);
            step();
            #1;
        end
        ts_end_ready = 1'b1;
        #1;
        step();
        #1;
        chk("cc_end_released", ts_end_valid, 0);

        // end request from a non-owner (ID 0 is owned by requester 1)
        req_end_valid = 4'b1000;
        #1;
        chk("own_end_ready", req_end_ready, 4'b1000);
`ifdef TS_ID_OWNER_CHECK_EN
        chk("own_err_pulse", owner_err, 1);
`else
        chk("own_err_pulse", owner_err, 0);
`endif
        step();
        req_end_valid = '0;
        #1;
        chk("own_err_cleared", owner_err, 0);
`ifdef TS_ID_OWNER_CHECK_EN
        chk("own_forwarded", ts_end_valid, 0);
`else
        chk("own_forwarded", ts_end_valid, 1);
`endif

        // asynchronous reset while a start is being issued
        do_reset();
        ts_start_ready = 1'b0;
        req_start_valid = 4'b0001;
        step();
        #1;
        chk("ar_issue_valid", ts_start_valid, 1);
        chk("ar_issue_cnt", free_cnt, 15);
        rst = 1'b1;
        #1;
        chk("ar_ts_start_valid", ts_start_valid, 0);
        chk("ar_start_ready", req_start_ready, 0);
        chk("ar_free_cnt", free_cnt, 16);
        step();
        rst = 1'b0; req_start_valid = '0;
        ts_out_valid = 1'b1; ts_out_ready = 1'b1; ts_out_id = '0;
        step();
        ts_out_valid = 1'b0;
        #1;
        chk("ar_stale_out_cnt", free_cnt, 16);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < NID; i++) begin m_free[i] = 1'b1; m_own[i] = 0; end
        m_sptr = 0; m_eptr = 0; m_sb = 1'b0; m_eb = 1'b0; m_sid = 0; m_eid = 0;
        for (int c = 0; c < 3000; c++) begin
            req_start_valid = N'($urandom);
            req_end_valid   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            req_end_id      = (N*W)'($urandom);
            ts_start_ready  = 1'($urandom);
            ts_end_ready    = 1'($urandom);
            ts_out_valid    = ($urandom_range(0, 2) == 0);
            ts_out_ready    = 1'($urandom);
            ts_out_id       = W'($urandom);
            #1;
            model_cycle();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
